instr_loader: RTL and testbench
===============================

# instr_loader

Writable instruction store directly upstream of the microprocessor core: it accepts a program as a byte stream over a valid/ready handshake, then serves the core's `pc` with a zero-latency `instruction` byte. It replaces a hardwired program table so programs can be loaded at run time. While a program is loading, it holds the core in reset.

## Interface
Parameters:
- `DEPTH`, 32: number of instruction bytes stored (2..256).
- `FILL_INSTR`, 8'b11000011: byte returned for unloaded or out-of-range addresses.

Ports:
- `origclk` in 1: sole clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `load_start` in 1: single-cycle pulse; starts a new load.
- `load_valid` in 1: `load_data` is valid this cycle.
- `load_data` in 8: program byte.
- `load_last` in 1: qualifies the final beat of the stream.
- `load_ready` out 1: loader accepts a beat this cycle.
- `pc` in 8: core program counter.
- `instruction` out 8: byte at `pc`, combinational.
- `cpu_hold` out 1: high keeps the core in reset.
- `loaded_count` out 8: number of bytes stored by the last load.
- `load_error` out 1: sticky error flag, cleared by `load_start`.

## Operation
- States: IDLE, LOAD, RUN.
- Reset values: state = IDLE, `cpu_hold`=1, `load_ready`=0, `loaded_count`=0, `load_error`=0, write pointer = 0. Array contents are not reset.
- IDLE: `cpu_hold`=1. `load_start` moves to LOAD.
- LOAD: `load_ready`=1 and `cpu_hold`=1.
  - Each beat with `load_valid`&`load_ready` writes `mem[wptr]` and increments `wptr`. `loaded_count` tracks `wptr`.
  - When `wptr`==DEPTH, further beats are accepted and discarded, and `load_error` is set.
  - A beat with `load_last` ends the load and moves to RUN. This applies even if `load_error` is set.
- RUN: `cpu_hold`=0. `instruction` = `mem[pc]` if `pc` < `loaded_count`, else FILL_INSTR.
- In IDLE and LOAD, `instruction` = FILL_INSTR.
- `load_start` in any state: go to LOAD, set `wptr`=0 and `loaded_count`=0, clear `load_error`, assert `cpu_hold`.
  - If `load_start` coincides with an accepted beat, the beat is discarded and `load_start` wins.
- `load_last` with no accepted bytes cannot occur; every beat carries data.
- A reset mid-load abandons the load. The state returns to IDLE and previously stored bytes become unreachable because the count is 0.

## Timing
- `load_ready` is a combinational decode of the state, with no dependence on `load_valid`.
- A write lands on the edge that accepts the beat. `loaded_count` updates on the same edge.
- The cycle after the `load_last` beat: state = RUN and `cpu_hold`=0.
- `instruction` has zero latency from `pc` and follows the array asynchronously.
- After `load_start`: `load_ready`=1 from the next cycle. `cpu_hold`=1 from the next cycle, or unchanged if already high.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - The `load_last` beat is a checksum byte and is not stored.
  - The loader keeps a running XOR of the stored bytes, reset by `load_start`.
  - If the XOR equals the checksum, the loader moves to RUN.
  - On a mismatch, it sets `load_error`, forces `loaded_count` to 0, and goes to IDLE with `cpu_hold`=1.
- Undefined: the `load_last` beat is ordinary data and there is no checksum logic.

## Structure
- Shared package `instr_loader_pkg` holds:
  - the state enum {IDLE, LOAD, RUN};
  - the default FILL_INSTR constant;
  - the opcode field positions [7:6] for debug decode.
- Sub-module `imem_array`: DEPTH×8 register file with one synchronous write port and one asynchronous read port. It performs the range check externally.

## Test plan
- Reset, then `pc`=0..3 → `instruction`=8'hC3, `cpu_hold`=1, `loaded_count`=0.
- Load 4 bytes 8'h44, 8'h49, 8'h19, 8'h84 (last on 8'h84) → the next cycle gives RUN with `cpu_hold`=0. `pc`=2 → 8'h19; `pc`=4 → 8'hC3; `loaded_count`=4.
- Load DEPTH+3 bytes → `load_error`=1, `loaded_count`=DEPTH, RUN is entered, and `pc`=DEPTH-1 returns the DEPTH-th byte.
- In RUN, pulse `load_start` while `load_valid` is high → that beat is not stored, `cpu_hold`=1 the next cycle, `loaded_count`=0, and `instruction`=8'hC3.
- Assert `reset` after 2 of 4 load beats → `load_ready`=0 and `cpu_hold`=1 immediately; reloading works.
- With `INSTR_LOADER_CHECKSUM_EN`:
  - bytes 8'h44, 8'h49 plus checksum 8'h0D → RUN, `loaded_count`=2;
  - checksum 8'h0E → IDLE, `load_error`=1.

Source files
------------

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader_pkg
// Description : Shared types and constants for the run-time instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [7:0] C_FILL_INSTR = 8'b11000011;

    // Opcode field of an instruction byte, for debug decode
    localparam int C_OPCODE_MSB = 7;
    localparam int C_OPCODE_LSB = 6;

    function automatic logic [1:0] opcode_of(input logic [7:0] instr);
        return instr[C_OPCODE_MSB:C_OPCODE_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : DEPTH x 8 register file, one synchronous write port and one
//               asynchronous read port. Address range checking is external.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_array #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Writable instruction store loaded over a valid/ready byte
//               stream; holds the core in reset while a program is loading.
//               Optional macro INSTR_LOADER_CHECKSUM_EN: the last beat is an
//               XOR checksum of the stored bytes instead of program data.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int         DEPTH      = 32,
    parameter logic [7:0] FILL_INSTR = C_FILL_INSTR
) (
    input  logic       origclk,
    input  logic       reset,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic [7:0] pc,
    output logic [7:0] instruction,
    output logic       cpu_hold,
    output logic [7:0] loaded_count,
    output logic       load_error
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = 9;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic          r_error;
    logic          w_accept;
    logic          w_full;
    logic          w_store;
    logic          w_in_range;
    logic [7:0]    w_rdata;

    assign w_accept = load_valid & load_ready;
    assign w_full   = (r_count == C_DEPTH);

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    // The checksum beat itself is never written into the array
    assign w_store = w_accept & ~load_start & ~load_last & ~w_full;
`else
    assign w_store = w_accept & ~load_start & ~w_full;
`endif

    always_ff @(posedge origclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        load_ready  = (r_state == LOAD);
        cpu_hold    = (r_state != RUN);
        if (load_start) begin
            w_state_nxt = LOAD;
        end else if (w_accept && load_last) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            w_state_nxt = (r_csum == load_data) ? RUN : IDLE;
`else
            w_state_nxt = RUN;
`endif
        end
    end

    always_ff @(posedge origclk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_error <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else if (load_start) begin
            r_count <= '0;
            r_error <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else if (w_accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (load_last) begin
                if (r_csum != load_data) begin
                    r_error <= 1'b1;
                    r_count <= '0;
                end
            end else if (w_full) begin
                r_error <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                r_csum  <= r_csum ^ load_data;
            end
`else
            if (w_full) begin
                r_error <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
`endif
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem_array (
        .clk   (origclk),
        .we    (w_store),
        .waddr (r_count[AW-1:0]),
        .wdata (load_data),
        .raddr (pc[AW-1:0]),
        .rdata (w_rdata)
    );

    assign w_in_range  = ({1'b0, pc} < r_count);
    assign instruction = ((r_state == RUN) && w_in_range) ? w_rdata : FILL_INSTR;

    // A full 256-byte program saturates the 8-bit count report at 255
    assign loaded_count = r_count[CW-1] ? 8'hFF : r_count[7:0];
    assign load_error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_loader
// Description : Directed self-checking bench for instr_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int DEPTH = 32;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       origclk    = 1'b0;
    logic       reset      = 1'b1;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data  = 8'h00;
    logic       load_last  = 1'b0;
    logic [7:0] pc         = 8'h00;
    logic       load_ready;
    logic [7:0] instruction;
    logic       cpu_hold;
    logic [7:0] loaded_count;
    logic       load_error;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] prog[$];

    always #5 origclk = ~origclk;

    instr_loader #(
        .DEPTH      (DEPTH),
        .FILL_INSTR (8'hC3)
    ) dut (
        .origclk      (origclk),
        .reset        (reset),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .pc           (pc),
        .instruction  (instruction),
        .cpu_hold     (cpu_hold),
        .loaded_count (loaded_count),
        .load_error   (load_error)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge origclk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 8'h00;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] exp);
        pc = a;
        #1;
        chk(tag, instruction, exp);
    endtask

    // Streams prog; in checksum builds a trailing XOR beat of the stored bytes is added
    task automatic load_prog();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < prog.size(); i++) begin
            beat(prog[i], !CSUM && (i == prog.size() - 1));
            if (i < DEPTH) x = x ^ prog[i];
        end
        if (CSUM) beat(x, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_hold", {7'd0, cpu_hold}, 8'd1);
        chk("rst_ready", {7'd0, load_ready}, 8'd0);
        chk("rst_count", loaded_count, 8'd0);
        chk("rst_err", {7'd0, load_error}, 8'd0);
        for (int a = 0; a < 4; a++) peek("rst_instr", 8'(a), 8'hC3);

        // Basic 4-byte program
        start();
        chk("ld_ready", {7'd0, load_ready}, 8'd1);
        chk("ld_hold", {7'd0, cpu_hold}, 8'd1);
        prog = '{8'h44, 8'h49, 8'h19, 8'h84};
        load_prog();
        chk("run_hold", {7'd0, cpu_hold}, 8'd0);
        chk("run_ready", {7'd0, load_ready}, 8'd0);
        chk("run_count", loaded_count, 8'd4);
        peek("run_pc2", 8'd2, 8'h19);
        peek("run_pc0", 8'd0, 8'h44);
        peek("run_pc3", 8'd3, 8'h84);
        peek("run_pc4", 8'd4, 8'hC3);

        // Overflow: DEPTH+3 bytes, extras discarded
        start();
        prog = {};
        for (int i = 0; i < DEPTH + 3; i++) prog.push_back(8'((i * 7) + 3));
        load_prog();
        chk("ovf_err", {7'd0, load_error}, 8'd1);
        chk("ovf_count", loaded_count, 8'd32);
        chk("ovf_hold", {7'd0, cpu_hold}, 8'd0);
        peek("ovf_pc31", 8'd31, 8'hDC);
        peek("ovf_pc0", 8'd0, 8'h03);
        peek("ovf_pc32", 8'd32, 8'hC3);

        // load_start in RUN with a valid beat present
        load_valid = 1'b1;
        load_data  = 8'hAA;
        start();
        load_valid = 1'b0;
        chk("rst_run_hold", {7'd0, cpu_hold}, 8'd1);
        chk("rst_run_count", loaded_count, 8'd0);
        chk("rst_run_err", {7'd0, load_error}, 8'd0);
        chk("rst_run_ready", {7'd0, load_ready}, 8'd1);
        peek("rst_run_pc0", 8'd0, 8'hC3);

        // load_start coinciding with an accepted beat in LOAD: beat dropped
        load_valid = 1'b1;
        load_data  = 8'h55;
        start();
        load_valid = 1'b0;
        chk("coll_count", loaded_count, 8'd0);
        prog = '{8'h11, 8'h22};
        load_prog();
        chk("coll_count2", loaded_count, 8'd2);
        peek("coll_pc0", 8'd0, 8'h11);
        peek("coll_pc1", 8'd1, 8'h22);

        // Reset in the middle of a load
        start();
        beat(8'h44, 1'b0);
        beat(8'h49, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {7'd0, load_ready}, 8'd0);
        chk("mid_rst_hold", {7'd0, cpu_hold}, 8'd1);
        chk("mid_rst_count", loaded_count, 8'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_idle", {7'd0, load_ready}, 8'd0);
        start();
        prog = '{8'h44, 8'h49, 8'h19, 8'h84};
        load_prog();
        chk("reload_count", loaded_count, 8'd4);
        chk("reload_hold", {7'd0, cpu_hold}, 8'd0);
        peek("reload_pc1", 8'd1, 8'h49);

`ifdef INSTR_LOADER_CHECKSUM_EN
        start();
        beat(8'h44, 1'b0);
        beat(8'h49, 1'b0);
        beat(8'h0D, 1'b1);
        chk("cs_ok_hold", {7'd0, cpu_hold}, 8'd0);
        chk("cs_ok_count", loaded_count, 8'd2);
        chk("cs_ok_err", {7'd0, load_error}, 8'd0);
        peek("cs_ok_pc1", 8'd1, 8'h49);
        start();
        beat(8'h44, 1'b0);
        beat(8'h49, 1'b0);
        beat(8'h0E, 1'b1);
        chk("cs_bad_hold", {7'd0, cpu_hold}, 8'd1);
        chk("cs_bad_err", {7'd0, load_error}, 8'd1);
        chk("cs_bad_count", loaded_count, 8'd0);
        chk("cs_bad_ready", {7'd0, load_ready}, 8'd0);
        peek("cs_bad_pc0", 8'd0, 8'hC3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
